fp_alu_mode_scheduler: RTL and testbench

- Shares one dual-mode floating-point ALU (dot product / vector multiply, selected by a single mode line) between a dot-product requester and a vector-multiply requester.
- Issues one operation per cycle to the current mode and counts operations still in flight.
- Before flipping the mode, it drains the ALU to zero in-flight operations. The ALU gates its result valids with the mode, so flipping early would lose results.
- Sits between the LCMV sequencing FSMs and the ALU. It provides the ALU's ready strobe and mode select.

---
 rtl/fp_alu_pkg.sv | 24 ++
 rtl/fp_alu_inflight_counter.sv | 41 ++++
 rtl/fp_alu_mode_scheduler.sv | 144 ++++++++++++++
 tb/tb_fp_alu_mode_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_alu_pkg.sv
// Shared types and default latencies for the dual-mode floating-point ALU
// and the scheduler that arbitrates access to it.
package fp_alu_pkg;

    typedef enum logic {
        MODE_VM = 1'b0,
        MODE_DP = 1'b1
    } alu_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sched_state_t;

    localparam int DEF_DP_LATENCY = 45;
    localparam int DEF_VM_LATENCY = 8;
    localparam int DEF_MAX_BURST  = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/fp_alu_inflight_counter.sv
// Up/down counter of ALU operations in flight. A return with nothing in
// flight holds the count at zero and raises a sticky underflow flag.
module fp_alu_inflight_counter #(
    parameter int CNT_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_inc,
    input  logic                 i_dec,
    output logic [CNT_WIDTH-1:0] o_count,
    output logic                 o_underflow
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] r_count;
    logic                 r_underflow;

    // Track issues minus returns; simultaneous issue and return cancel out.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count     <= '0;
            r_underflow <= 1'b0;
        end else if (i_inc && !i_dec) begin
            if (r_count != CNT_MAX) begin
                r_count <= r_count + CNT_ONE;
            end
        end else if (i_dec && !i_inc) begin
            if (r_count == '0) begin
                r_underflow <= 1'b1;
            end else begin
                r_count <= r_count - CNT_ONE;
            end
        end
    end

    assign o_count     = r_count;
    assign o_underflow = r_underflow;

endmodule

// File: rtl/fp_alu_mode_scheduler.sv
// Arbitrates one dual-mode FP ALU between a dot-product and a
// vector-multiply requester. The ALU drops result valids that do not match
// its current mode, so the mode only flips once every issued operation has
// returned.
module fp_alu_mode_scheduler
    import fp_alu_pkg::*;
#(
    parameter int DP_LATENCY = DEF_DP_LATENCY,
    parameter int VM_LATENCY = DEF_VM_LATENCY,
    parameter int MAX_BURST  = DEF_MAX_BURST,
    parameter int CNT_WIDTH  = $clog2(max_int(DP_LATENCY, VM_LATENCY) + 2)
) (
    input  logic clk,
    input  logic rst,
    input  logic dp_req,
    output logic dp_gnt,
    input  logic vm_req,
    output logic vm_gnt,
    output logic alu_ready,
    output logic alu_dot_product_mode,
    input  logic alu_dp_valid,
    input  logic alu_vm_valid,
    output logic dp_result_valid,
    output logic vm_result_valid,
    output logic busy,
    output logic protocol_error
);

    localparam int                BW        = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0]     BURST_MAX = BW'(MAX_BURST);
    localparam logic [BW-1:0]     BURST_ONE = BW'(1);

    sched_state_t         r_state;
    alu_mode_t            r_mode;
    alu_mode_t            r_last_served;
    logic [BW-1:0]        r_burst_cnt;

    logic                 w_own_req;
    logic                 w_other_req;
    logic                 w_switch_now;
    logic                 w_run;
    logic                 w_grant;
    logic                 w_return;
    logic                 w_underflow;
    logic [CNT_WIDTH-1:0] w_in_flight;
    alu_mode_t            w_target;
    alu_mode_t            w_flipped;

    assign w_own_req    = (r_mode == MODE_DP) ? dp_req : vm_req;
    assign w_other_req  = (r_mode == MODE_DP) ? vm_req : dp_req;
    // Yield when the own side has nothing, or it has used up its burst
    // while the other side waits.
    assign w_switch_now = w_other_req & (~w_own_req | (r_burst_cnt == BURST_MAX));
    assign w_run        = (r_state == RUN);
    assign w_flipped    = (r_mode == MODE_DP) ? MODE_VM : MODE_DP;

    assign dp_gnt    = w_run & (r_mode == MODE_DP) & dp_req & ~w_switch_now;
    assign vm_gnt    = w_run & (r_mode == MODE_VM) & vm_req & ~w_switch_now;
    assign w_grant   = dp_gnt | vm_gnt;
    assign alu_ready = w_grant;
    assign w_return  = alu_dp_valid | alu_vm_valid;

    assign alu_dot_product_mode = (r_mode == MODE_DP);
    assign dp_result_valid      = alu_dp_valid & (r_mode == MODE_DP);
    assign vm_result_valid      = alu_vm_valid & (r_mode == MODE_VM);
    assign busy                 = (w_in_flight != '0) | (r_state != IDLE);
    assign protocol_error       = w_underflow;

    // From IDLE, pick the mode to serve; with both waiting, alternate.
    always_comb begin
        w_target = r_mode;
        if (dp_req && vm_req) begin
            w_target = (r_last_served == MODE_DP) ? MODE_VM : MODE_DP;
        end else if (dp_req) begin
            w_target = MODE_DP;
        end else if (vm_req) begin
            w_target = MODE_VM;
        end
    end

    // Mode/arbitration FSM: mode changes only when entering RUN.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_mode        <= MODE_DP;
            r_last_served <= MODE_VM;
            r_burst_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (dp_req || vm_req) begin
                        r_burst_cnt <= '0;
                        if (w_target == r_mode) begin
                            r_state <= RUN;
                        end else if (w_in_flight == '0) begin
                            r_mode  <= w_target;
                            r_state <= RUN;
                        end else begin
                            r_state <= DRAIN;
                        end
                    end
                end
                RUN: begin
                    if (w_switch_now) begin
                        r_state     <= DRAIN;
                        r_burst_cnt <= '0;
                    end else if (!dp_req && !vm_req) begin
                        r_state     <= IDLE;
                        r_burst_cnt <= '0;
                    end else if (w_grant) begin
                        r_last_served <= r_mode;
                        if (r_burst_cnt != BURST_MAX) begin
                            r_burst_cnt <= r_burst_cnt + BURST_ONE;
                        end
                    end
                end
                DRAIN: begin
                    // Registered count is used, so issue resumes no earlier
                    // than one cycle after the last result returns.
                    if (w_in_flight == '0) begin
                        r_mode      <= w_flipped;
                        r_burst_cnt <= '0;
                        r_state     <= RUN;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    fp_alu_inflight_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_inflight (
        .clk         (clk),
        .rst         (rst),
        .i_inc       (w_grant),
        .i_dec       (w_return),
        .o_count     (w_in_flight),
        .o_underflow (w_underflow)
    );

endmodule

// File: tb/tb_fp_alu_mode_scheduler.sv
// Bench for fp_alu_mode_scheduler: a delay-line ALU model returns results,
// and a scoreboard expects each grant's result at grant cycle + latency.
module tb_fp_alu_mode_scheduler;

    localparam int DP_LAT = 45;
    localparam int VM_LAT = 8;
    localparam int MAXB   = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic dp_req = 1'b0;
    logic vm_req = 1'b0;
    logic dp_gnt, vm_gnt, alu_ready, alu_dot_product_mode;
    logic alu_dp_valid, alu_vm_valid;
    logic dp_result_valid, vm_result_valid, busy, protocol_error;
    logic inj_dp = 1'b0;
    logic sb_ignore = 1'b0;
    logic log_en = 1'b0;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    int   dp_q[$];
    int   vm_q[$];
    int   log_cyc[$];
    logic log_dp[$];

    logic [DP_LAT-1:0] dp_pipe = '0;
    logic [VM_LAT-1:0] vm_pipe = '0;

    always #5 clk = ~clk;

    fp_alu_mode_scheduler #(
        .DP_LATENCY (DP_LAT),
        .VM_LATENCY (VM_LAT),
        .MAX_BURST  (MAXB)
    ) u_dut (
        .clk                  (clk),
        .rst                  (rst),
        .dp_req               (dp_req),
        .dp_gnt               (dp_gnt),
        .vm_req               (vm_req),
        .vm_gnt               (vm_gnt),
        .alu_ready            (alu_ready),
        .alu_dot_product_mode (alu_dot_product_mode),
        .alu_dp_valid         (alu_dp_valid),
        .alu_vm_valid         (alu_vm_valid),
        .dp_result_valid      (dp_result_valid),
        .vm_result_valid      (vm_result_valid),
        .busy                 (busy),
        .protocol_error       (protocol_error)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ALU model: fixed-latency delay lines, reset together with the scheduler.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            dp_pipe <= '0;
            vm_pipe <= '0;
        end else begin
            dp_pipe <= {dp_pipe[DP_LAT-2:0], alu_ready & alu_dot_product_mode};
            vm_pipe <= {vm_pipe[VM_LAT-2:0], alu_ready & ~alu_dot_product_mode};
        end
    end
    assign alu_dp_valid = dp_pipe[DP_LAT-1] | inj_dp;
    assign alu_vm_valid = vm_pipe[VM_LAT-1];

    // Scoreboard: expected result cycles pushed on grant, popped on arrival.
    always @(negedge clk) begin
        if (!rst) begin
            dp_q.delete();
            vm_q.delete();
        end else begin
            check("alu_ready", alu_ready, dp_gnt | vm_gnt);
            if (dp_gnt) dp_q.push_back(cyc + DP_LAT);
            if (vm_gnt) vm_q.push_back(cyc + VM_LAT);
            if (dp_q.size() > 0 && dp_q[0] == cyc) begin
                check("dp_result_due", dp_result_valid, 1);
                void'(dp_q.pop_front());
            end else if (dp_result_valid && !sb_ignore) begin
                check("dp_result_unexpected", dp_result_valid, 0);
            end
            if (vm_q.size() > 0 && vm_q[0] == cyc) begin
                check("vm_result_due", vm_result_valid, 1);
                void'(vm_q.pop_front());
            end else if (vm_result_valid && !sb_ignore) begin
                check("vm_result_unexpected", vm_result_valid, 0);
            end
            if (log_en && (dp_gnt || vm_gnt)) begin
                log_cyc.push_back(cyc);
                log_dp.push_back(dp_gnt);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check(tag, busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int exp_cyc[$];
        logic exp_dp[$];
        int run_len;
        int max_run;

        // Reset values
        tick();
        tick();
        check("rst_dp_gnt", dp_gnt, 0);
        check("rst_vm_gnt", vm_gnt, 0);
        check("rst_alu_ready", alu_ready, 0);
        check("rst_mode", alu_dot_product_mode, 1);
        check("rst_busy", busy, 0);
        check("rst_perr", protocol_error, 0);
        check("rst_dp_rv", dp_result_valid, 0);
        check("rst_vm_rv", vm_result_valid, 0);
        check("rst_inflight", u_dut.w_in_flight, 0);
        rst = 1'b1;

        // Five DP grants after one IDLE->RUN cycle
        tick();
        dp_req = 1'b1;
        #1;
        c0 = cyc;
        for (int i = 0; i < 6; i++) begin
            check("t1_dp_gnt", dp_gnt, (i > 0) ? 1 : 0);
            check("t1_vm_gnt", vm_gnt, 0);
            tick();
        end
        dp_req = 1'b0;
        #1;
        check("t1_inflight_peak", u_dut.w_in_flight, 5);
        check("t1_busy", busy, 1);
        wait_idle("t1_idle_timeout", 200);
        check("t1_busy_fall_cycle", cyc, c0 + 5 + DP_LAT + 1);

        // Switch VM -> DP waits for the last VM result
        tick();
        vm_req = 1'b1;
        #1;
        c0 = cyc;
        for (int i = 0; i < 4; i++) begin
            check("t2_vm_gnt", vm_gnt, (i > 0) ? 1 : 0);
            if (i > 0) check("t2_mode_vm", alu_dot_product_mode, 0);
            tick();
        end
        vm_req = 1'b0;
        dp_req = 1'b1;
        #1;
        while (cyc <= c0 + 3 + VM_LAT + 1) begin
            check("t2_mode_held", alu_dot_product_mode, 0);
            check("t2_dp_gnt_blocked", dp_gnt, 0);
            tick();
        end
        check("t2_mode_flipped", alu_dot_product_mode, 1);
        check("t2_dp_gnt_resume", dp_gnt, 1);
        tick();
        dp_req = 1'b0;
        #1;
        wait_idle("t2_idle_timeout", 200);

        // Fairness: both held; last served was DP, so VM goes first
        tick();
        dp_req = 1'b1;
        vm_req = 1'b1;
        log_en = 1'b1;
        #1;
        c0 = cyc;
        for (int k = 1; k <= MAXB; k++) begin
            exp_cyc.push_back(c0 + k);
            exp_dp.push_back(1'b0);
        end
        for (int k = 0; k < MAXB; k++) begin
            exp_cyc.push_back(c0 + MAXB + VM_LAT + 2 + k);
            exp_dp.push_back(1'b1);
        end
        for (int k = 0; k < MAXB; k++) begin
            exp_cyc.push_back(c0 + 2 * MAXB + VM_LAT + DP_LAT + 3 + k);
            exp_dp.push_back(1'b0);
        end
        while (cyc < exp_cyc[exp_cyc.size()-1] + 1) tick();
        log_en = 1'b0;
        dp_req = 1'b0;
        vm_req = 1'b0;
        #1;
        check("t3_grant_count", log_cyc.size(), exp_cyc.size());
        for (int j = 0; j < exp_cyc.size() && j < log_cyc.size(); j++) begin
            check("t3_grant_cycle", log_cyc[j] - c0, exp_cyc[j] - c0);
            check("t3_grant_mode", log_dp[j], exp_dp[j]);
        end
        run_len = 0;
        max_run = 0;
        for (int j = 0; j < log_dp.size(); j++) begin
            run_len = (j > 0 && log_dp[j] == log_dp[j-1]) ? run_len + 1 : 1;
            if (run_len > max_run) max_run = run_len;
        end
        check("t3_max_burst", max_run, MAXB);
        wait_idle("t3_idle_timeout", 200);

        // Issue and return in the same cycle leave the count unchanged
        tick();
        vm_req = 1'b1;
        #1;
        c0 = cyc;
        tick();
        check("t4_vm_gnt_a", vm_gnt, 1);
        tick();
        check("t4_vm_gnt_b", vm_gnt, 1);
        tick();
        vm_req = 1'b0;
        #1;
        check("t4_vm_gnt_off", vm_gnt, 0);
        while (cyc < c0 + 8) tick();
        vm_req = 1'b1;
        #1;
        check("t4_idle_no_gnt", vm_gnt, 0);
        tick();
        check("t4_inflight_before", u_dut.w_in_flight, 2);
        check("t4_alu_ready", alu_ready, 1);
        check("t4_alu_vm_valid", alu_vm_valid, 1);
        tick();
        check("t4_inflight_after", u_dut.w_in_flight, 2);
        vm_req = 1'b0;
        #1;
        wait_idle("t4_idle_timeout", 200);

        // Spurious result with nothing in flight (mode is VM here)
        tick();
        sb_ignore = 1'b1;
        inj_dp = 1'b1;
        #1;
        check("t5_perr_same_cycle", protocol_error, 0);
        check("t5_dp_rv_gated", dp_result_valid, 0);
        tick();
        inj_dp = 1'b0;
        #1;
        check("t5_perr_set", protocol_error, 1);
        check("t5_inflight_zero", u_dut.w_in_flight, 0);
        repeat (3) tick();
        check("t5_perr_sticky", protocol_error, 1);
        sb_ignore = 1'b0;

        // Reset in the middle of a drain
        tick();
        vm_req = 1'b1;
        #1;
        c0 = cyc;
        while (cyc < c0 + 7) tick();
        vm_req = 1'b0;
        dp_req = 1'b1;
        #1;
        check("t6_switch_no_gnt", vm_gnt | dp_gnt, 0);
        tick();
        check("t6_inflight", u_dut.w_in_flight, 6);
        check("t6_mode_held", alu_dot_product_mode, 0);
        check("t6_busy", busy, 1);
        rst = 1'b0;
        #1;
        check("t6_drain_no_gnt", dp_gnt, 0);
        tick();
        check("t6_rst_mode", alu_dot_product_mode, 1);
        check("t6_rst_inflight", u_dut.w_in_flight, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_dp_gnt", dp_gnt, 0);
        check("t6_rst_vm_gnt", vm_gnt, 0);
        check("t6_rst_perr", protocol_error, 0);
        dp_req = 1'b0;
        rst = 1'b1;
        #1;
        repeat (12) tick();
        check("t6_post_busy", busy, 0);
        check("t6_post_perr", protocol_error, 0);

        check("sb_empty", dp_q.size() + vm_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
